// File: rtl/flex_gray_ptr.sv
// Gray-coded FIFO pointer half: local binary/Gray pointer, remote pointer synchroniser, full/empty flag, level.
// Optional registered "almost" flag under FLEX_GRAY_PTR_ALMOST_EN.
module flex_gray_ptr #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter bit IS_WRITE    = 1'b1
`ifdef FLEX_GRAY_PTR_ALMOST_EN
  , parameter int ALMOST_THRESH = 1
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic [WIDTH:0]   remote_gray,
  output logic [WIDTH-1:0] addr,
  output logic [WIDTH:0]   gray_ptr,
  output logic             flag,
  output logic [WIDTH:0]   level,
  output logic             inc_err
`ifdef FLEX_GRAY_PTR_ALMOST_EN
  , output logic           almost
`endif
);

  localparam int PW = WIDTH + 1;

  function automatic logic [WIDTH:0] gray2bin(input logic [WIDTH:0] g);
    logic [WIDTH:0] b;
    b[WIDTH] = g[WIDTH];
    for (int i = WIDTH - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  function automatic logic [WIDTH:0] occupancy(input logic [WIDTH:0] local_bin,
                                               input logic [WIDTH:0] remote_bin);
    return IS_WRITE ? (local_bin - remote_bin) : (remote_bin - local_bin);
  endfunction

  logic [WIDTH:0] bin_ptr;
  logic [WIDTH:0] bin_next;
  logic [WIDTH:0] gray_next;
  logic [WIDTH:0] sync_r [SYNC_STAGES];
  logic [WIDTH:0] sync_q;
  logic [WIDTH:0] full_pat;
  logic           inc_eff;
  logic           flag_next;

  assign inc_eff   = inc & ~flag;
  assign bin_next  = bin_ptr + {{WIDTH{1'b0}}, inc_eff};
  assign gray_next = bin_next ^ (bin_next >> 1);
  assign sync_q    = sync_r[SYNC_STAGES-1];
  // Full: remote pointer one lap behind, i.e. top two Gray bits inverted.
  assign full_pat  = {~sync_q[WIDTH:WIDTH-1], sync_q[WIDTH-2:0]};
  assign flag_next = IS_WRITE ? (gray_next == full_pat) : (gray_next == sync_q);

  assign addr  = bin_ptr[WIDTH-1:0];
  assign level = occupancy(bin_ptr, gray2bin(sync_q));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_ptr  <= '0;
      gray_ptr <= '0;
      flag     <= ~IS_WRITE;
      inc_err  <= 1'b0;
      for (int i = 0; i < SYNC_STAGES; i++) sync_r[i] <= '0;
    end else begin
      bin_ptr   <= bin_next;
      gray_ptr  <= gray_next;
      flag      <= flag_next;
      inc_err   <= inc & flag;
      sync_r[0] <= remote_gray;
      for (int i = 1; i < SYNC_STAGES; i++) sync_r[i] <= sync_r[i-1];
    end
  end

`ifdef FLEX_GRAY_PTR_ALMOST_EN
  logic [WIDTH:0] sync_nq;
  logic [WIDTH:0] level_next;
  logic           almost_next;

  // Value sync_q will hold after the coming edge, so almost tracks level exactly.
  if (SYNC_STAGES == 1) begin : g_sn_direct
    assign sync_nq = remote_gray;
  end else begin : g_sn_chain
    assign sync_nq = sync_r[SYNC_STAGES-2];
  end

  assign level_next  = occupancy(bin_next, gray2bin(sync_nq));
  assign almost_next = IS_WRITE ? (level_next >= ((PW'(1) << WIDTH) - PW'(ALMOST_THRESH)))
                                : (level_next <= PW'(ALMOST_THRESH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) almost <= ~IS_WRITE;
    else     almost <= almost_next;
  end
`endif

endmodule

// File: tb/tb_flex_gray_ptr.sv
// Directed self-checking bench for flex_gray_ptr: one write-side and one read-side instance.
module tb_flex_gray_ptr;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         inc_w, inc_r;
  logic [W:0]   rem_w, rem_r;
  logic [W-1:0] addr_w, addr_r;
  logic [W:0]   gray_w, gray_r;
  logic         flag_w, flag_r;
  logic [W:0]   level_w, level_r;
  logic         err_w, err_r;
`ifdef FLEX_GRAY_PTR_ALMOST_EN
  logic         almost_w, almost_r;
`endif

  int checks;
  int failures;

  flex_gray_ptr #(
    .WIDTH(W), .SYNC_STAGES(2), .IS_WRITE(1'b1)
`ifdef FLEX_GRAY_PTR_ALMOST_EN
    , .ALMOST_THRESH(2)
`endif
  ) u_wr (
    .clk(clk), .rst(rst), .inc(inc_w), .remote_gray(rem_w),
    .addr(addr_w), .gray_ptr(gray_w), .flag(flag_w), .level(level_w), .inc_err(err_w)
`ifdef FLEX_GRAY_PTR_ALMOST_EN
    , .almost(almost_w)
`endif
  );

  flex_gray_ptr #(
    .WIDTH(W), .SYNC_STAGES(2), .IS_WRITE(1'b0)
`ifdef FLEX_GRAY_PTR_ALMOST_EN
    , .ALMOST_THRESH(2)
`endif
  ) u_rd (
    .clk(clk), .rst(rst), .inc(inc_r), .remote_gray(rem_r),
    .addr(addr_r), .gray_ptr(gray_r), .flag(flag_r), .level(level_r), .inc_err(err_r)
`ifdef FLEX_GRAY_PTR_ALMOST_EN
    , .almost(almost_r)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, failures=%0d", failures);
    $fatal(1, "timeout");
  end

  function automatic logic [W:0] to_gray(input logic [W:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic do_reset();
    rst   = 1'b1;
    inc_w = 1'b0;
    inc_r = 1'b0;
    rem_w = '0;
    rem_r = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; inc_w = 1'b0; inc_r = 1'b0; rem_w = '0; rem_r = '0;
    #3;
    checks += 6;
    if (gray_w !== 5'd0)  begin failures++; $display("FAIL reset_gray_w got=%b exp=%b", gray_w, 5'd0); end
    if (addr_w !== 4'd0)  begin failures++; $display("FAIL reset_addr_w got=%0d exp=0", addr_w); end
    if (flag_w !== 1'b0)  begin failures++; $display("FAIL reset_flag_w got=%b exp=0", flag_w); end
    if (level_w !== 5'd0) begin failures++; $display("FAIL reset_level_w got=%0d exp=0", level_w); end
    if (err_w !== 1'b0)   begin failures++; $display("FAIL reset_inc_err_w got=%b exp=0", err_w); end
    if (flag_r !== 1'b1)  begin failures++; $display("FAIL reset_flag_r got=%b exp=1", flag_r); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_gray_wrap();
    logic [W:0] b;
    logic [W:0] prev;
    logic [W:0] exp_lvl;
    do_reset();
    b = '0;
    prev = '0;
    for (int k = 1; k <= 40; k++) begin
      rem_w = to_gray(b);       // reader keeps pace with the writer
      inc_w = 1'b1;
      tick();
      b = b + 5'd1;
      exp_lvl = (k < 2) ? 5'(k) : 5'd2;
      checks += 4;
      if (gray_w !== to_gray(b)) begin failures++; $display("FAIL gray_step%0d got=%b exp=%b", k, gray_w, to_gray(b)); end
      if ($countones(gray_w ^ prev) != 1) begin failures++; $display("FAIL gray_onebit%0d got=%b prev=%b exp=one bit change", k, gray_w, prev); end
      if (addr_w !== b[W-1:0]) begin failures++; $display("FAIL gray_addr%0d got=%0d exp=%0d", k, addr_w, b[W-1:0]); end
      if (level_w !== exp_lvl || flag_w !== 1'b0) begin failures++; $display("FAIL gray_level%0d got=%0d/%b exp=%0d/0", k, level_w, flag_w, exp_lvl); end
      prev = gray_w;
    end
    inc_w = 1'b0;
  endtask

  task automatic test_full_block();
    do_reset();
    rem_w = '0;
    for (int i = 1; i <= 16; i++) begin
      inc_w = 1'b1;
      tick();
      checks += 2;
      if (flag_w !== (i == 16)) begin failures++; $display("FAIL full_flag%0d got=%b exp=%b", i, flag_w, (i == 16)); end
      if (level_w !== 5'(i))    begin failures++; $display("FAIL full_level%0d got=%0d exp=%0d", i, level_w, i); end
    end
    inc_w = 1'b1;                 // 17th request is blocked
    tick();
    checks += 4;
    if (gray_w !== 5'b11000) begin failures++; $display("FAIL full_hold_gray got=%b exp=11000", gray_w); end
    if (addr_w !== 4'd0)     begin failures++; $display("FAIL full_hold_addr got=%0d exp=0", addr_w); end
    if (err_w !== 1'b1)      begin failures++; $display("FAIL full_inc_err got=%b exp=1", err_w); end
    if (level_w !== 5'd16 || flag_w !== 1'b1) begin failures++; $display("FAIL full_hold_state got=%0d/%b exp=16/1", level_w, flag_w); end
    inc_w = 1'b0;
    tick();
    checks += 1;
    if (err_w !== 1'b0) begin failures++; $display("FAIL full_inc_err_pulse got=%b exp=0", err_w); end
  endtask

  task automatic test_empty_latency();
    do_reset();
    rem_r = 5'b00001;
    tick();
    checks += 2;
    if (level_r !== 5'd0 || flag_r !== 1'b1) begin failures++; $display("FAIL empty_edge1 got=%0d/%b exp=0/1", level_r, flag_r); end
    if (gray_r !== 5'd0) begin failures++; $display("FAIL empty_gray_r got=%b exp=00000", gray_r); end
    tick();
    checks += 1;
    if (level_r !== 5'd1 || flag_r !== 1'b1) begin failures++; $display("FAIL empty_edge2 got=%0d/%b exp=1/1", level_r, flag_r); end
    tick();
    checks += 1;
    if (level_r !== 5'd1 || flag_r !== 1'b0) begin failures++; $display("FAIL empty_edge3 got=%0d/%b exp=1/0", level_r, flag_r); end
    inc_r = 1'b1;
    tick();
    checks += 2;
    if (level_r !== 5'd0 || flag_r !== 1'b1) begin failures++; $display("FAIL empty_pop got=%0d/%b exp=0/1", level_r, flag_r); end
    if (addr_r !== 4'd1 || err_r !== 1'b0)   begin failures++; $display("FAIL empty_pop_addr got=%0d/%b exp=1/0", addr_r, err_r); end
    tick();                       // inc still high while empty: blocked
    checks += 1;
    if (addr_r !== 4'd1 || err_r !== 1'b1) begin failures++; $display("FAIL empty_block got=%0d/%b exp=1/1", addr_r, err_r); end
    inc_r = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    rem_w = '0;
    inc_w = 1'b1;
    for (int i = 0; i < 9; i++) tick();
    checks += 1;
    if (level_w !== 5'd9) begin failures++; $display("FAIL mid_level9 got=%0d exp=9", level_w); end
    #2;
    rst = 1'b1;
    #1;
    checks += 2;
    if (gray_w !== 5'd0 || addr_w !== 4'd0 || level_w !== 5'd0) begin failures++; $display("FAIL mid_reset_ptr got=%b/%0d/%0d exp=0/0/0", gray_w, addr_w, level_w); end
    if (flag_w !== 1'b0 || err_w !== 1'b0) begin failures++; $display("FAIL mid_reset_flags got=%b/%b exp=0/0", flag_w, err_w); end
    @(negedge clk);
    rst = 1'b0;
    tick();
    checks += 1;
    if (addr_w !== 4'd1 || level_w !== 5'd1) begin failures++; $display("FAIL mid_restart got=%0d/%0d exp=1/1", addr_w, level_w); end
    inc_w = 1'b0;
  endtask

`ifdef FLEX_GRAY_PTR_ALMOST_EN
  task automatic test_almost();
    do_reset();
    checks += 1;
    if (almost_w !== 1'b0 || almost_r !== 1'b1) begin failures++; $display("FAIL almost_reset got=%b/%b exp=0/1", almost_w, almost_r); end
    inc_w = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      tick();
      checks += 1;
      if (almost_w !== (i >= 14) || flag_w !== 1'b0) begin failures++; $display("FAIL almost_wr%0d got=%b/%b exp=%b/0", i, almost_w, flag_w, (i >= 14)); end
    end
    inc_w = 1'b0;
    rem_r = 5'b00010;             // Gray of 3
    tick();
    tick();
    checks += 1;
    if (level_r !== 5'd3 || almost_r !== 1'b0) begin failures++; $display("FAIL almost_rd3 got=%0d/%b exp=3/0", level_r, almost_r); end
    inc_r = 1'b1;
    tick();
    inc_r = 1'b0;
    checks += 1;
    if (level_r !== 5'd2 || almost_r !== 1'b1) begin failures++; $display("FAIL almost_rd2 got=%0d/%b exp=2/1", level_r, almost_r); end
  endtask
`endif

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_gray_wrap();
    test_full_block();
    test_empty_latency();
    test_reset_mid();
`ifdef FLEX_GRAY_PTR_ALMOST_EN
    test_almost();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
